// File: rtl/if_pc_gen_pkg.sv
// if_pc_gen_pkg
// Shared types and constants for the IF-stage PC generator slice:
//   - BTB entry record (valid, target and, with IF_PC_GEN_BHT_EN, a 2-bit counter)
//   - 2-bit counter encodings SNT/WNT/WT/ST
//   - default RESET_PC and BTB index width
//   - next-PC source select encoding
// Optional feature macro: IF_PC_GEN_BHT_EN (adds per-entry saturating counters).
package if_pc_gen_pkg;

  localparam int unsigned BTB_IDX_W_DEF = 4;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'h0000_0004;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  // The tag is kept in a separate array inside the BTB because its width
  // depends on the index-width parameter.
  typedef struct packed {
    logic        valid;
    logic [31:0] target;
`ifdef IF_PC_GEN_BHT_EN
    ctr_e        ctr;
`endif
  } btb_entry_t;

  typedef enum logic [2:0] {
    SEL_MISP_T  = 3'd0,
    SEL_MISP_NT = 3'd1,
    SEL_JALR    = 3'd2,
    SEL_HOLD    = 3'd3,
    SEL_JAL     = 3'd4,
    SEL_PRED    = 3'd5,
    SEL_SEQ     = 3'd6
  } next_sel_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  function automatic btb_entry_t btb_entry_reset();
    btb_entry_t e;
    e.valid  = 1'b0;
    e.target = 32'h0000_0000;
`ifdef IF_PC_GEN_BHT_EN
    e.ctr    = WNT;
`endif
    return e;
  endfunction

`ifdef IF_PC_GEN_BHT_EN
  function automatic ctr_e ctr_inc(input ctr_e c);
    logic [1:0] v;
    v = c;
    return (c == ST) ? ST : ctr_e'(v + 2'd1);
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    logic [1:0] v;
    v = c;
    return (c == SNT) ? SNT : ctr_e'(v - 2'd1);
  endfunction
`endif

endpackage

// File: rtl/if_pc_gen_if.sv
// if_pc_gen_if
// Bundles the PC generator's pipeline-facing signals.
//   master: pipeline side (drives stall/redirect/branch resolution, observes PCF)
//   slave : PC generator (drives PCF, PredTakenF, MispredE)
interface if_pc_gen_if;
  logic        en;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic        JalD;
  logic [31:0] JalTargetD;
  logic        JalrE;
  logic [31:0] JalrTargetE;
  logic        BranchE;
  logic        BrTakenE;
  logic [31:0] BrTargetE;
  logic [31:0] PCE;
  logic        PredTakenE;
  logic        MispredE;

  modport master (
    output en, JalD, JalTargetD, JalrE, JalrTargetE,
           BranchE, BrTakenE, BrTargetE, PCE, PredTakenE,
    input  PCF, PredTakenF, MispredE
  );

  modport slave (
    input  en, JalD, JalTargetD, JalrE, JalrTargetE,
           BranchE, BrTakenE, BrTargetE, PCE, PredTakenE,
    output PCF, PredTakenF, MispredE
  );
endinterface

// File: rtl/if_pc_gen_btb_dm.sv
// btb_dm
// Direct-mapped branch target buffer, 2**IDX_W entries.
//   clk, rst              : clock, asynchronous active-high reset (clears all entries)
//   rd_pc                 : lookup address (combinational read port)
//   rd_taken, rd_target   : prediction for rd_pc
//   wr_en, wr_pc          : resolved branch present, and its PC
//   wr_taken, wr_target   : resolved outcome and target
// Index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]; pc[1:0] is ignored.
// With IF_PC_GEN_BHT_EN each entry carries a 2-bit counter and the taken
// decision is ctr[1]; otherwise a hit alone predicts taken and a not-taken
// resolution on a hit invalidates the entry.
module btb_dm import if_pc_gen_pkg::*; #(
  parameter int unsigned IDX_W = BTB_IDX_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc,
  output logic        rd_taken,
  output logic [31:0] rd_target,
  input  logic        wr_en,
  input  logic        wr_taken,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_target
);

  localparam int unsigned N     = 32'd1 << IDX_W;
  localparam int unsigned TAG_W = 32'd30 - IDX_W;

  btb_entry_t         entry_q [N];
  btb_entry_t         entry_d [N];
  logic [TAG_W-1:0]   tag_q   [N];
  logic [TAG_W-1:0]   tag_d   [N];

  logic [IDX_W-1:0]   rd_idx_s;
  logic [TAG_W-1:0]   rd_tag_s;
  logic               rd_hit_s;
  logic [IDX_W-1:0]   wr_idx_s;
  logic [TAG_W-1:0]   wr_tag_s;
  logic               wr_hit_s;
  logic               unused_ok;

  assign rd_idx_s = rd_pc[IDX_W+1:2];
  assign rd_tag_s = rd_pc[31:IDX_W+2];
  assign wr_idx_s = wr_pc[IDX_W+1:2];
  assign wr_tag_s = wr_pc[31:IDX_W+2];
  // Byte offset within the word never participates in index or tag.
  assign unused_ok = ^{rd_pc[1:0], wr_pc[1:0]};

  assign rd_hit_s  = entry_q[rd_idx_s].valid && (tag_q[rd_idx_s] == rd_tag_s);
  assign wr_hit_s  = entry_q[wr_idx_s].valid && (tag_q[wr_idx_s] == wr_tag_s);
  assign rd_target = entry_q[rd_idx_s].target;
`ifdef IF_PC_GEN_BHT_EN
  assign rd_taken  = rd_hit_s && entry_q[rd_idx_s].ctr[1];
`else
  assign rd_taken  = rd_hit_s;
`endif

  // Next BTB contents: at most one entry changes per cycle, at the PCE index.
  always_comb begin
    entry_d = entry_q;
    tag_d   = tag_q;
    if (wr_en) begin
      if (wr_taken) begin
        // Allocate on miss (overwriting any alias) or refresh on hit.
        entry_d[wr_idx_s].valid  = 1'b1;
        entry_d[wr_idx_s].target = wr_target;
        tag_d[wr_idx_s]          = wr_tag_s;
`ifdef IF_PC_GEN_BHT_EN
        if (wr_hit_s) begin
          entry_d[wr_idx_s].ctr = ctr_inc(entry_q[wr_idx_s].ctr);
        end else begin
          entry_d[wr_idx_s].ctr = WT;
        end
`endif
      end else if (wr_hit_s) begin
`ifdef IF_PC_GEN_BHT_EN
        entry_d[wr_idx_s].ctr = ctr_dec(entry_q[wr_idx_s].ctr);
`else
        entry_d[wr_idx_s].valid = 1'b0;
`endif
      end else begin
        // Not taken and not present: nothing to learn.
        entry_d[wr_idx_s] = entry_q[wr_idx_s];
      end
    end else begin
      entry_d = entry_q;
    end
  end

  // BTB storage; reset invalidates every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        entry_q[i] <= btb_entry_reset();
        tag_q[i]   <= {TAG_W{1'b0}};
      end
    end else begin
      entry_q <= entry_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: rtl/if_pc_gen.sv
// if_pc_gen
// IF-stage program counter generator with direct-mapped BTB prediction.
//   clk  : clock
//   rst  : asynchronous active-high reset (PCF <= RESET_PC, BTB cleared)
//   bus  : if_pc_gen_if.slave -- en (0 = stall), JAL/JALR/branch redirect
//          inputs, PCF fetch address, PredTakenF, MispredE (combinational)
// Next-PC priority: mispredict (taken target / PCE+4), JALR, stall hold,
// JAL, BTB prediction, PC+4. Redirects from EX override the stall.
// Optional feature macro: IF_PC_GEN_BHT_EN (2-bit counters in the BTB).
module if_pc_gen import if_pc_gen_pkg::*; #(
  parameter int unsigned BTB_IDX_W = BTB_IDX_W_DEF,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  if_pc_gen_if.slave   bus
);

  logic [31:0] pcf_q;
  logic [31:0] pcf_d;
  logic        pred_taken_s;
  logic [31:0] pred_target_s;
  logic        mispred_s;
  next_sel_e   sel_s;

  btb_dm #(.IDX_W(BTB_IDX_W)) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (pcf_q),
    .rd_taken  (pred_taken_s),
    .rd_target (pred_target_s),
    .wr_en     (bus.BranchE),
    .wr_taken  (bus.BrTakenE),
    .wr_pc     (bus.PCE),
    .wr_target (bus.BrTargetE)
  );

  // Only the direction is checked: a tag hit implies the stored target is right.
  assign mispred_s = bus.BranchE && (bus.BrTakenE != bus.PredTakenE);

  // Pick the next-PC source in priority order.
  always_comb begin
    sel_s = SEL_SEQ;
    if (mispred_s && bus.BrTakenE) begin
      sel_s = SEL_MISP_T;
    end else if (mispred_s) begin
      sel_s = SEL_MISP_NT;
    end else if (bus.JalrE) begin
      sel_s = SEL_JALR;
    end else if (!bus.en) begin
      sel_s = SEL_HOLD;
    end else if (bus.JalD) begin
      sel_s = SEL_JAL;
    end else if (pred_taken_s) begin
      sel_s = SEL_PRED;
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // Next-PC value for the selected source.
  always_comb begin
    pcf_d = pc_plus4(pcf_q);
    case (sel_s)
      SEL_MISP_T:  pcf_d = bus.BrTargetE;
      SEL_MISP_NT: pcf_d = pc_plus4(bus.PCE);
      SEL_JALR:    pcf_d = bus.JalrTargetE;
      SEL_HOLD:    pcf_d = pcf_q;
      SEL_JAL:     pcf_d = bus.JalTargetD;
      SEL_PRED:    pcf_d = pred_target_s;
      SEL_SEQ:     pcf_d = pc_plus4(pcf_q);
      default:     pcf_d = pc_plus4(pcf_q);
    endcase
  end

  // Fetch PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf_q <= RESET_PC;
    end else begin
      pcf_q <= pcf_d;
    end
  end

  assign bus.PCF        = pcf_q;
  assign bus.PredTakenF = pred_taken_s;
  assign bus.MispredE   = mispred_s;

endmodule

// File: doc/if_pc_gen.md
Name: if_pc_gen

Overview:
- IF-stage program counter generator; sits directly upstream of the ID segment register and drives its fetch address (PCF).
- Selects the next PC from these sources:
  - EX-stage branch resolution and JALR.
  - ID-stage JAL.
  - A direct-mapped branch target buffer (BTB) prediction.
  - The sequential PC+4.
- Updates the BTB from resolved branches and reports mispredictions to the hazard unit.

Parameters:
- BTB_IDX_W, 4, log2 of BTB entries (16 entries); legal range 1..8.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  PC advance enable (0 = StallF, hold PC)
- PCF  out  32  current fetch address, fed to ID segment register and instruction RAM
- PredTakenF  out  1  BTB predicts PCF is a taken branch; piped down to EX as PredTakenE
- JalD  in  1  JAL decoded in ID
- JalTargetD  in  32  JAL target
- JalrE  in  1  JALR executing in EX
- JalrTargetE  in  32  JALR target (bit 0 already cleared)
- BranchE  in  1  conditional branch in EX, valid this cycle
- BrTakenE  in  1  actual branch outcome
- BrTargetE  in  32  branch target
- PCE  in  32  PC of EX instruction
- PredTakenE  in  1  prediction that travelled with the EX instruction
- MispredE  out  1  combinational; EX redirect due to misprediction (hazard unit flushes ID and EX)

Behaviour:
- Reset:
  - PCF=RESET_PC.
  - All BTB valid bits = 0.
  - Counters = 2'b01.
  - As a consequence, PredTakenF=0 and MispredE=0 out of reset.
- BTB entry fields: valid, tag = PC[31:BTB_IDX_W+2], target[31:0], ctr[1:0].
  - Index = PC[BTB_IDX_W+1:2].
  - PC[1:0] is ignored.
- Lookup is combinational on PCF.
  - hitF = valid && tag match.
  - PredTakenF = hitF && taken-decision (see Optional Feature).
  - PredTargetF = entry target.
- MispredE = BranchE && (BrTakenE != PredTakenE).
  - No target-mismatch check: the tag is the full upper PC and targets are PC-relative, so a hit target is always correct.
- Next-PC priority, registered on posedge clk:
  1. MispredE && BrTakenE -> BrTargetE.
  2. MispredE && !BrTakenE -> PCE+4.
  3. JalrE -> JalrTargetE.
  4. if en=0 -> hold PCF.
  5. JalD -> JalTargetD.
  6. PredTakenF -> PredTargetF.
  7. Otherwise -> PCF+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
- Sources 1–3 override the stall; JAL and prediction are ignored while stalled.
- MispredE and JalrE never coincide; if both are asserted, the MispredE rule wins.
- One-cycle latency from any redirect input to PCF.
- BTB update happens on posedge clk when BranchE=1, independent of en. The EX stage must present each branch exactly once (bubbles on stall).
  - Update index/tag are taken from PCE.
  - Taken, entry hit: target=BrTargetE, ctr saturating increment (3 stays 3).
  - Taken, miss: allocate valid=1, tag, target, ctr=2'b10 (overwrite any alias).
  - Not taken, hit: ctr saturating decrement (0 stays 0).
  - Not taken, miss: no change.
- A same-cycle update and lookup on the same index: lookup sees the old entry (no bypass).
- Reset asserted mid-operation: PCF=RESET_PC immediately (asynchronous) and the BTB is cleared.

Optional Feature:
- Macro: IF_PC_GEN_BHT_EN.
- Defined:
  - Taken decision = ctr[1].
  - Counters are stored and updated as above.
- Undefined:
  - No counters are synthesised; taken decision = hitF.
  - Not-taken update on a hit clears valid for that entry.
  - Taken update allocates or refreshes the entry.

Decomposition:
- Shared package:
  - BTB entry struct/typedef.
  - Counter encodings SNT=0, WNT=1, WT=2, ST=3.
  - RESET_PC default.
  - Next-PC select enum (SEL_MISP_T, SEL_MISP_NT, SEL_JALR, SEL_HOLD, SEL_JAL, SEL_PRED, SEL_SEQ).
- One sub-module: btb_dm. Direct-mapped storage with a combinational read port (PCF) and a registered write port (PCE update).
- Next-PC mux and PC register stay in if_pc_gen.

Test Plan:
- Reset and sequential fetch: release rst, en=1, no redirects -> PCF 0x0, 0x4, 0x8, 0xC on successive cycles; PredTakenF=0.
- Stall:
  - en=0 for 3 cycles at PCF=0x10 -> PCF holds 0x10.
  - JalD=1 with target 0x80 during the stall -> ignored.
  - After en=1 with JalD=1 -> PCF=0x80.
- Cold mispredict, then prediction:
  - BranchE=1, PCE=0x20, BrTakenE=1, PredTakenE=0, BrTargetE=0x100 -> MispredE=1, next PCF=0x100.
  - Later, when PCF=0x20 -> PredTakenF=1 and next PCF=0x100.
- Counter hysteresis (BHT_EN defined):
  - From the allocated 0x20 entry (ctr=2), resolve not-taken once -> ctr=1, PredTakenF=0 at 0x20.
  - Resolve taken twice -> ctr=3.
  - Resolve not-taken once -> still predicts taken.
  - Without BHT_EN: one not-taken -> entry invalid.
- Redirect during stall:
  - en=0, JalrE=1, JalrTargetE=0x200 -> next PCF=0x200.
  - Same setup with MispredE (PCE=0x40, not taken, PredTakenE=1) -> next PCF=0x44.
- Async reset mid-run: assert rst between clock edges at PCF=0x1C4 -> PCF=RESET_PC immediately. Previously trained 0x20 no longer predicts taken.
